// File: rtl/seq110_frame_tx.sv
// Serial frame transmitter: a 1,1,0 preamble, then the payload MSB first.
// Optional macro SEQ110_BIT_STUFF_EN inserts a 0 after every payload 1 so "110" never occurs in the payload.
module seq110_frame_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             dataout,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SEQ110_BIT_STUFF_EN
    typedef enum logic [1:0] {IDLE, PRE, DATA, STUFF} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       pre_idx_q, pre_idx_d;
    logic             dataout_q, dataout_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             next_data;
    logic             go_idle;

    assign ready      = (state_q == IDLE) && enable;
    assign dataout    = dataout_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // The state names what is on the line now; cnt_q counts payload bits not yet sent.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        pre_idx_d    = pre_idx_q;
        dataout_d    = dataout_q;
        busy_d       = busy_q;
        frame_done_d = frame_done_q;
        next_data    = 1'b0;
        go_idle      = 1'b0;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d      = PRE;
                        pre_idx_d    = 2'd0;
                        shift_d      = data_in;
                        cnt_d        = CW'(WIDTH);
                        dataout_d    = 1'b1;
                        busy_d       = 1'b1;
                        frame_done_d = 1'b0;
                    end
                end
                PRE: begin
                    if (pre_idx_q != 2'd2) begin
                        pre_idx_d = pre_idx_q + 2'd1;
                        dataout_d = (pre_idx_q != 2'd1);
                    end else begin
                        next_data = 1'b1;
                    end
                end
                DATA: begin
`ifdef SEQ110_BIT_STUFF_EN
                    if (dataout_q) begin
                        state_d      = STUFF;
                        dataout_d    = 1'b0;
                        frame_done_d = (cnt_q == '0);
                    end else
`endif
                    if (cnt_q == '0) begin
                        go_idle = 1'b1;
                    end else begin
                        next_data = 1'b1;
                    end
                end
`ifdef SEQ110_BIT_STUFF_EN
                STUFF: begin
                    if (cnt_q == '0) begin
                        go_idle = 1'b1;
                    end else begin
                        next_data = 1'b1;
                    end
                end
`endif
                default: begin
                    go_idle = 1'b1;
                end
            endcase

            if (next_data) begin
                state_d      = DATA;
                dataout_d    = shift_q[WIDTH-1];
                shift_d      = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d        = cnt_q - CW'(1);
`ifdef SEQ110_BIT_STUFF_EN
                frame_done_d = (cnt_q == CW'(1)) && !shift_q[WIDTH-1];
`else
                frame_done_d = (cnt_q == CW'(1));
`endif
            end

            if (go_idle) begin
                state_d      = IDLE;
                dataout_d    = 1'b0;
                busy_d       = 1'b0;
                frame_done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            pre_idx_q    <= 2'd0;
            dataout_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            pre_idx_q    <= pre_idx_d;
            dataout_q    <= dataout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seq110_frame_tx.sv
// Self-checking bench for seq110_frame_tx: randomized words checked against a bit-list model of the frame.
module tb_seq110_frame_tx;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] dataIn;
   logic       load;
   logic       ready;
   logic       dataout;
   logic       busy;
   logic       frameDone;

   int checkCount;
   int passCount;
   bit expBits[$];
   bit lineModel[$];
   logic [2:0] detHist;
   int  detHits;
   bit  detOn;
   bit  detFlag;

   seq110_frame_tx #(.WIDTH(8)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .data_in(dataIn),
      .load(load),
      .ready(ready),
      .dataout(dataout),
      .busy(busy),
      .frame_done(frameDone)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Expected line content of one frame, built straight from the framing rules
   task automatic buildExpected(input logic [7:0] w);
      expBits = {};
      expBits.push_back(1'b1);
      expBits.push_back(1'b1);
      expBits.push_back(1'b0);
      for (int b = 7; b >= 0; b--) begin
         expBits.push_back(w[b]);
`ifdef SEQ110_BIT_STUFF_EN
         if (w[b]) expBits.push_back(1'b0);
`endif
      end
   endtask

   function automatic int count110(input bit q[$]);
      int n = 0;
      for (int i = 2; i < q.size(); i++)
         if (q[i-2] && q[i-1] && !q[i]) n++;
      return n;
   endfunction

   // Advance one clock and sample just after the edge; also feeds the reference 110 detector
   task automatic stepCycle();
      @(posedge clk);
      #1;
      detFlag = 1'b0;
      if (detOn) begin
         detHist = {detHist[1:0], dataout};
         if (detHist == 3'b110) begin
            detHits++;
            detFlag = 1'b1;
         end
      end
   endtask

   // Send one word and follow it bit by bit; optional stall, abort by reset, or held load
   task automatic applyStimulus(input logic [7:0] w, input int stallIdx, input int abortAt,
                                input bit holdLoad, input logic [7:0] nextWord);
      int waitCount = 0;
      int len;
      buildExpected(w);
      len = expBits.size();
      while (!ready && waitCount < 50) begin
         stepCycle();
         waitCount++;
      end
      if (!ready) begin
         checkOutput("ready_timeout", 32'(ready), 32'd1);
         return;
      end
      load   = 1'b1;
      dataIn = w;
      stepCycle();
      if (holdLoad) dataIn = nextWord;
      else load = 1'b0;
      for (int i = 0; i < len; i++) begin
         checkOutput("dataout", 32'(dataout), 32'(expBits[i]));
         checkOutput("busy", 32'(busy), 32'd1);
         checkOutput("frame_done", 32'(frameDone), 32'(i == len - 1));
         checkOutput("ready_busy", 32'(ready), 32'd0);
         if (holdLoad) lineModel.push_back(expBits[i]);
`ifdef SEQ110_BIT_STUFF_EN
         if (detOn && detFlag) checkOutput("det_pos", i, 32'd2);
`endif
         if (i == abortAt) begin
            #2 reset = 1'b0;
            #1;
            checkOutput("abort_dataout", 32'(dataout), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_fd", 32'(frameDone), 32'd0);
            checkOutput("abort_ready", 32'(ready), 32'd1);
            #1 reset = 1'b1;
            load = 1'b0;
            return;
         end
         if (i == stallIdx) begin
            enable = 1'b0;
            load   = 1'b1;
            dataIn = ~w;
            repeat (4) begin
               stepCycle();
               checkOutput("stall_dataout", 32'(dataout), 32'(expBits[i]));
               checkOutput("stall_ready", 32'(ready), 32'd0);
               checkOutput("stall_busy", 32'(busy), 32'd1);
               checkOutput("stall_fd", 32'(frameDone), 32'(i == len - 1));
            end
            enable = 1'b1;
            if (holdLoad) dataIn = nextWord;
            else begin
               load   = 1'b0;
               dataIn = w;
            end
         end
         if (i < len - 1) stepCycle();
      end
      stepCycle();
      checkOutput("idle_dataout", 32'(dataout), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_fd", 32'(frameDone), 32'd0);
      checkOutput("idle_ready", 32'(ready), 32'd1);
      if (holdLoad) lineModel.push_back(1'b0);
`ifdef SEQ110_BIT_STUFF_EN
      if (detOn) checkOutput("det_idle", 32'(detFlag), 32'd0);
`endif
   endtask

   initial begin
      logic [7:0] words[6];
      logic [7:0] w;
      int stallIdx;
      checkCount = 0;
      passCount  = 0;
      detOn      = 1'b0;
      detFlag    = 1'b0;
      detHist    = 3'b000;
      detHits    = 0;
      reset      = 1'b0;
      enable     = 1'b1;
      load       = 1'b0;
      dataIn     = 8'h00;

      #2;
      checkOutput("rst_dataout", 32'(dataout), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_fd", 32'(frameDone), 32'd0);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      #10 reset = 1'b1;

      applyStimulus(8'hA5, -1, -1, 1'b0, 8'h00);
      applyStimulus(8'h00, -1, -1, 1'b0, 8'h00);
      applyStimulus(8'hFF, -1, 6, 1'b0, 8'h00);
      applyStimulus(8'hFF, -1, -1, 1'b0, 8'h00);
      applyStimulus(8'hA5, 1, -1, 1'b0, 8'h00);

      for (int k = 0; k < 8; k++) begin
         w = 8'($urandom_range(0, 255));
         buildExpected(w);
         if ($urandom_range(0, 1) == 1) stallIdx = $urandom_range(0, expBits.size() - 1);
         else stallIdx = -1;
         applyStimulus(w, stallIdx, -1, 1'b0, 8'h00);
      end

      for (int k = 0; k < 6; k++) words[k] = (k % 2 == 0) ? 8'hC3 : 8'h3C;
      lineModel = {};
      lineModel.push_back(1'b0);
      detHist = 3'b000;
      detHits = 0;
      detOn   = 1'b1;
      for (int k = 0; k < 6; k++)
         applyStimulus(words[k], -1, -1, 1'b1, (k < 5) ? words[k+1] : 8'h00);
      load  = 1'b0;
      detOn = 1'b0;
      checkOutput("det_count", detHits, count110(lineModel));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Guard against any unbounded stall
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checkCount);
      $fatal(1);
   end

endmodule
